axi_stream_strip_header: RTL and testbench

//  Receive-side counterpart of the header inserter. Removes a per-packet header of 0..DATA_BYTE_WD

---
 rtl/axi_stream_strip_header.sv | 162 ++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_strip_header.sv
// rtl/axi_stream_strip_header.sv - strips a 0..DATA_BYTE_WD byte leading header and realigns the payload
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    strip_cnt,
  output logic                    ready_strip,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);
  localparam int CW = BYTE_CNT_WD + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DW_CNT = cnt_t'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, BODY, FLUSH} state_t;
  state_t state, state_nxt;

  cnt_t               hdr_cnt, resid_cnt;
  logic [DATA_WD-1:0] resid;

  function automatic logic [DATA_BYTE_WD-1:0] keep_mask(input cnt_t n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input cnt_t n);
    logic [DATA_WD-1:0]      m;
    logic [DATA_BYTE_WD-1:0] k;
    k = keep_mask(n);
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  cnt_t               in_cnt, k_cnt, min_hk, tail_cnt, h_clamp;
  logic [DATA_WD-1:0] shifted;
  logic               out_free;

  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) in_cnt = in_cnt + cnt_t'(keep_in[i]);
  end

  // Only the last beat of a packet may be short; keep_in on earlier beats is ignored.
  assign k_cnt    = last_in ? in_cnt : DW_CNT;
  assign min_hk   = (k_cnt < hdr_cnt) ? k_cnt : hdr_cnt;
  assign tail_cnt = (k_cnt > hdr_cnt) ? k_cnt - hdr_cnt : '0;
  assign shifted  = data_in << {hdr_cnt, 3'b000};
  assign h_clamp  = (strip_cnt > DW_CNT) ? DW_CNT : strip_cnt;
  assign out_free = !valid_out || ready_out;

  logic               out_load, out_last_nxt, in_fire;
  logic [DATA_WD-1:0] out_data_nxt;
  cnt_t               out_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    ready_in     = 1'b0;
    ready_strip  = 1'b0;
    in_fire      = 1'b0;
    out_load     = 1'b0;
    out_data_nxt = '0;
    out_cnt_nxt  = '0;
    out_last_nxt = 1'b0;
    case (state)
      IDLE: begin
        ready_strip = 1'b1;
        if (valid_strip) state_nxt = FIRST;
      end
      FIRST: begin
        ready_in = !valid_hdr && out_free;
        in_fire  = valid_in && ready_in;
        if (in_fire) begin
          state_nxt = last_in ? IDLE : BODY;
          if (last_in && tail_cnt != '0) begin
            out_load     = 1'b1;
            out_data_nxt = shifted & byte_mask(tail_cnt);
            out_cnt_nxt  = tail_cnt;
            out_last_nxt = 1'b1;
          end
        end
      end
      BODY: begin
        ready_in = out_free;
        in_fire  = valid_in && ready_in;
        if (in_fire) begin
          // Residual tail of the previous beat followed by the head of this one.
          out_load     = 1'b1;
          out_data_nxt = resid | ((data_in & byte_mask(min_hk)) >> {resid_cnt, 3'b000});
          out_cnt_nxt  = resid_cnt + min_hk;
          out_last_nxt = last_in && (tail_cnt == '0);
          if (last_in) state_nxt = (tail_cnt == '0) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_load     = 1'b1;
          out_data_nxt = resid;
          out_cnt_nxt  = resid_cnt;
          out_last_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr_cnt   <= '0;
      resid     <= '0;
      resid_cnt <= '0;
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && valid_strip) hdr_cnt <= h_clamp;
      if (in_fire) begin
        resid     <= shifted & byte_mask(tail_cnt);
        resid_cnt <= tail_cnt;
      end
      if (state == FIRST && in_fire) begin
        valid_hdr <= 1'b1;
        data_hdr  <= data_in;
        keep_hdr  <= keep_mask(min_hk);
      end else if (ready_hdr) begin
        valid_hdr <= 1'b0;
      end
      if (out_load) begin
        valid_out <= 1'b1;
        data_out  <= out_data_nxt;
        keep_out  <= keep_mask(out_cnt_nxt);
        last_out  <= out_last_nxt;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_strip_header.sv
// tb/tb_axi_stream_strip_header.sv - randomized self-checking bench for axi_stream_strip_header
module tb_axi_stream_strip_header;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        valid_in = 1'b0, last_in = 1'b0, ready_in;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        valid_strip = 1'b0, ready_strip;
  logic [2:0]  strip_cnt = '0;
  logic        valid_hdr, ready_hdr = 1'b1;
  logic [31:0] data_hdr;
  logic [3:0]  keep_hdr;
  logic        valid_out, last_out, ready_out = 1'b1;
  logic [31:0] data_out;
  logic [3:0]  keep_out;

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_strip(valid_strip), .strip_cnt(strip_cnt), .ready_strip(ready_strip),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out)
  );

  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct packed { logic [31:0] data; logic [3:0] keep; } hdr_t;

  beat_t got_out[$], exp_out[$];
  hdr_t  got_hdr[$], exp_hdr[$];
  int    n_checks = 0, n_fail = 0, hold_viol = 0;
  int    ro_mode = 0, rh_mode = 0;   // 0: held high, 1: random, 2: driven by the test
  bit    gaps = 0;

  function automatic logic [3:0] mask4(input int n);
    return 4'hF << (4 - n);
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (ro_mode == 0) ready_out = 1'b1;
    else if (ro_mode == 1) ready_out = ($urandom_range(0, 1) == 1);
    if (rh_mode == 0) ready_hdr = 1'b1;
    else if (rh_mode == 1) ready_hdr = ($urandom_range(0, 3) != 0);
  end

  beat_t prev_out;
  hdr_t  prev_hdr;
  bit    prev_ostall = 0, prev_hstall = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (prev_ostall && (!valid_out || {data_out, keep_out, last_out} !== prev_out)) hold_viol++;
      if (prev_hstall && (!valid_hdr || {data_hdr, keep_hdr} !== prev_hdr)) hold_viol++;
      if (valid_out && ready_out) got_out.push_back({data_out, keep_out, last_out});
      if (valid_hdr && ready_hdr) got_hdr.push_back({data_hdr, keep_hdr});
      prev_ostall = valid_out && !ready_out;
      prev_hstall = valid_hdr && !ready_hdr;
      prev_out    = {data_out, keep_out, last_out};
      prev_hdr    = {data_hdr, keep_hdr};
    end else begin
      prev_ostall = 0;
      prev_hstall = 0;
    end
  end

  // Reference: flatten the packet to a byte stream, drop the header bytes, repack into 4-byte beats.
  task automatic model_pkt(input int h_raw, input beat_t p[$]);
    logic [7:0]  bytes[$];
    logic [31:0] d;
    int h, k, k0, strip, n;
    k0 = 0;
    h = (h_raw > 4) ? 4 : h_raw;
    foreach (p[i]) begin
      k = p[i].last ? $countones(p[i].keep) : 4;
      if (i == 0) k0 = k;
      d = p[i].data;
      for (int j = 0; j < k; j++) bytes.push_back(d[31-8*j -: 8]);
    end
    strip = (h < k0) ? h : k0;
    exp_hdr.push_back({p[0].data, mask4(strip)});
    repeat (strip) void'(bytes.pop_front());
    while (bytes.size() > 0) begin
      beat_t b;
      n = (bytes.size() > 4) ? 4 : bytes.size();
      b.data = '0;
      for (int j = 0; j < n; j++) b.data[31-8*j -: 8] = bytes.pop_front();
      b.keep = mask4(n);
      b.last = (bytes.size() == 0);
      exp_out.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_strip(input logic [2:0] h);
    bit ok = 0;
    valid_strip = 1'b1; strip_cnt = h;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = ready_strip; tick(); end
    valid_strip = 1'b0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL strip_timeout ready_strip stayed 0, required 1"); end
  endtask

  task automatic send_beat(input beat_t b);
    bit ok = 0;
    valid_in = 1'b1; data_in = b.data; keep_in = b.keep; last_in = b.last;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = ready_in; tick(); end
    valid_in = 1'b0; last_in = 1'b0;
    if (!ok) begin n_checks++; n_fail++; $display("FAIL beat_timeout ready_in stayed 0, required 1"); end
  endtask

  task automatic send_pkt(input int h, input beat_t p[$]);
    send_strip(3'(h));
    foreach (p[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      send_beat(p[i]);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 400 && (got_out.size() < exp_out.size() || got_hdr.size() < exp_hdr.size()); c++) tick();
    repeat (8) tick();
  endtask

  task automatic clear_q();
    got_out.delete(); exp_out.delete(); got_hdr.delete(); exp_hdr.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({valid_hdr, valid_out, last_out} !== 3'b000) begin n_fail++; $display("FAIL reset_valids got %b required 000", {valid_hdr, valid_out, last_out}); end
    n_checks++;
    if ({data_out, keep_out, data_hdr, keep_hdr} !== 72'h0) begin n_fail++; $display("FAIL reset_data got %h required 0", {data_out, keep_out, data_hdr, keep_hdr}); end
    n_checks++;
    if ({ready_strip, ready_in} !== 2'b10) begin n_fail++; $display("FAIL reset_ready got %b required 10", {ready_strip, ready_in}); end
  endtask

  task automatic test_directed();
    beat_t p[$];
    clear_q(); ro_mode = 0; rh_mode = 0; gaps = 0;
    p = {}; p.push_back({32'h00010203, 4'hF, 1'b0}); p.push_back({32'h04050607, 4'hF, 1'b0}); p.push_back({32'h08090A0B, 4'hF, 1'b1});
    send_pkt(2, p);
    exp_hdr.push_back({32'h00010203, 4'b1100});
    exp_out.push_back({32'h02030405, 4'b1111, 1'b0}); exp_out.push_back({32'h06070809, 4'b1111, 1'b0}); exp_out.push_back({32'h0A0B0000, 4'b1100, 1'b1});
    p = {}; p.push_back({32'hAABBCCDD, 4'b1110, 1'b1});
    send_pkt(1, p);
    exp_hdr.push_back({32'hAABBCCDD, 4'b1000});
    exp_out.push_back({32'hBBCC0000, 4'b1100, 1'b1});
    p = {}; p.push_back({32'h11111111, 4'hF, 1'b0}); p.push_back({32'h22222222, 4'b1000, 1'b1});
    send_pkt(4, p);
    exp_hdr.push_back({32'h11111111, 4'b1111});
    exp_out.push_back({32'h22000000, 4'b1000, 1'b1});
    p = {}; p.push_back({32'h01020304, 4'hF, 1'b0}); p.push_back({32'h05060708, 4'b1110, 1'b1});
    send_pkt(3, p);
    exp_hdr.push_back({32'h01020304, 4'b1110});
    exp_out.push_back({32'h04050607, 4'b1111, 1'b1});
    drain();
    n_checks++;
    if (got_hdr.size() != exp_hdr.size()) begin n_fail++; $display("FAIL dir_hdr_count got %0d required %0d", got_hdr.size(), exp_hdr.size()); end
    foreach (exp_hdr[i]) if (i < got_hdr.size()) begin
      n_checks++;
      if (got_hdr[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL dir_hdr[%0d] got %h required %h", i, got_hdr[i], exp_hdr[i]); end
    end
    n_checks++;
    if (got_out.size() != exp_out.size()) begin n_fail++; $display("FAIL dir_out_count got %0d required %0d", got_out.size(), exp_out.size()); end
    foreach (exp_out[i]) if (i < got_out.size()) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL dir_out[%0d] got %h required %h", i, got_out[i], exp_out[i]); end
    end
  endtask

  task automatic test_random();
    beat_t p[$];
    int h, nb, k;
    clear_q(); hold_viol = 0; ro_mode = 1; rh_mode = 1; gaps = 1;
    for (int n = 0; n < 40; n++) begin
      p = {};
      h  = $urandom_range(0, 7);
      nb = $urandom_range(1, 5);
      for (int i = 0; i < nb; i++) begin
        beat_t b;
        b.data = $urandom;
        b.last = (i == nb - 1);
        if (b.last) begin
          k = $urandom_range(0, 4);
          if (k == 0 && h >= 4 && nb > 1) k = 1;
          b.keep = mask4(k);
        end else begin
          b.keep = 4'($urandom);
        end
        p.push_back(b);
      end
      model_pkt(h, p);
      send_pkt(h, p);
    end
    drain();
    n_checks++;
    if (got_hdr.size() != exp_hdr.size()) begin n_fail++; $display("FAIL rand_hdr_count got %0d required %0d", got_hdr.size(), exp_hdr.size()); end
    foreach (exp_hdr[i]) if (i < got_hdr.size()) begin
      n_checks++;
      if (got_hdr[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL rand_hdr[%0d] got %h required %h", i, got_hdr[i], exp_hdr[i]); end
    end
    n_checks++;
    if (got_out.size() != exp_out.size()) begin n_fail++; $display("FAIL rand_out_count got %0d required %0d", got_out.size(), exp_out.size()); end
    foreach (exp_out[i]) if (i < got_out.size()) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL rand_out[%0d] got %h required %h", i, got_out[i], exp_out[i]); end
    end
    n_checks++;
    if (hold_viol != 0) begin n_fail++; $display("FAIL rand_hold got %0d unstable stalled cycles required 0", hold_viol); end
  endtask

  task automatic test_stall();
    beat_t pa[$], pb[$];
    clear_q(); hold_viol = 0; ro_mode = 1; rh_mode = 2; ready_hdr = 1'b0; gaps = 0;
    pa.push_back({32'h00010203, 4'hF, 1'b0}); pa.push_back({32'h04050607, 4'hF, 1'b0}); pa.push_back({32'h08090A0B, 4'hF, 1'b1});
    pb.push_back({32'hAABBCCDD, 4'b1110, 1'b1});
    model_pkt(2, pa);
    model_pkt(1, pb);
    send_pkt(2, pa);
    send_strip(3'd1);
    valid_in = 1'b1; data_in = pb[0].data; keep_in = pb[0].keep; last_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (ready_in !== 1'b0) begin n_fail++; $display("FAIL stall_first_ready cycle %0d got %b required 0", c, ready_in); end
      tick();
    end
    ready_hdr = 1'b1;
    send_beat(pb[0]);
    drain();
    n_checks++;
    if (got_out.size() != exp_out.size()) begin n_fail++; $display("FAIL stall_out_count got %0d required %0d", got_out.size(), exp_out.size()); end
    foreach (exp_out[i]) if (i < got_out.size()) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL stall_out[%0d] got %h required %h", i, got_out[i], exp_out[i]); end
    end
    n_checks++;
    if (got_hdr.size() != exp_hdr.size()) begin n_fail++; $display("FAIL stall_hdr_count got %0d required %0d", got_hdr.size(), exp_hdr.size()); end
    foreach (exp_hdr[i]) if (i < got_hdr.size()) begin
      n_checks++;
      if (got_hdr[i] !== exp_hdr[i]) begin n_fail++; $display("FAIL stall_hdr[%0d] got %h required %h", i, got_hdr[i], exp_hdr[i]); end
    end
    n_checks++;
    if (hold_viol != 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable stalled cycles required 0", hold_viol); end
    rh_mode = 0;
  endtask

  task automatic test_reset_mid();
    beat_t pa[$];
    clear_q(); ro_mode = 2; rh_mode = 2; ready_out = 1'b0; ready_hdr = 1'b0; gaps = 0;
    pa.push_back({32'h00010203, 4'hF, 1'b0}); pa.push_back({32'h04050607, 4'hF, 1'b0}); pa.push_back({32'h08090A0B, 4'hF, 1'b1});
    send_strip(3'd2);
    send_beat(pa[0]);
    send_beat(pa[1]);
    n_checks++;
    if ({valid_hdr, valid_out} !== 2'b11) begin n_fail++; $display("FAIL rmid_pre valids got %b required 11", {valid_hdr, valid_out}); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid_hdr, valid_out, last_out} !== 3'b000) begin n_fail++; $display("FAIL rmid_valids got %b required 000", {valid_hdr, valid_out, last_out}); end
    n_checks++;
    if ({data_out, keep_out, data_hdr, keep_hdr} !== 72'h0) begin n_fail++; $display("FAIL rmid_data got %h required 0", {data_out, keep_out, data_hdr, keep_hdr}); end
    n_checks++;
    if ({ready_strip, ready_in} !== 2'b10) begin n_fail++; $display("FAIL rmid_ready got %b required 10", {ready_strip, ready_in}); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_q(); ro_mode = 1; rh_mode = 1;
    model_pkt(2, pa);
    send_pkt(2, pa);
    drain();
    n_checks++;
    if (got_out.size() != exp_out.size()) begin n_fail++; $display("FAIL rmid_out_count got %0d required %0d", got_out.size(), exp_out.size()); end
    foreach (exp_out[i]) if (i < got_out.size()) begin
      n_checks++;
      if (got_out[i] !== exp_out[i]) begin n_fail++; $display("FAIL rmid_out[%0d] got %h required %h", i, got_out[i], exp_out[i]); end
    end
    n_checks++;
    if (got_hdr.size() != 1 || got_hdr[0] !== exp_hdr[0]) begin n_fail++; $display("FAIL rmid_hdr got %0d headers first %h required 1 header %h", got_hdr.size(), (got_hdr.size() > 0) ? got_hdr[0] : 36'h0, exp_hdr[0]); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_directed();
    test_random();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
